// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO controller.
// Holds the word addresses of the four controller registers. Addresses are
// compared against the full bus address, so aliases never decode.
package gpio_pkg;

  localparam int GPIO_REG_OUT = 0;  // rw: output pin register
  localparam int GPIO_REG_IN  = 1;  // ro: filtered input value
  localparam int GPIO_REG_EVT = 2;  // rw1c: sticky rising-edge flags
  localparam int GPIO_REG_IEN = 3;  // rw: per-input interrupt enable

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-bit input filter for one synchronised GPIO input.
// Optional feature macro: GPIO_DEBOUNCE_EN.
//   defined     - the filtered output only follows the input after the input
//                 has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   not defined - the filter is a plain wire (out = in); clk, sync_rst and
//                 DEBOUNCE_CYCLES have no effect.
// Ports:
//   clk       in  system clock, rising edge
//   sync_rst  in  asynchronous active-low reset
//   in        in  synchronised input bit (already through the 2-flop sync)
//   out       out filtered input bit
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic sync_rst,
  input  logic in,
  output logic out
);

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_inc;
  logic             filt_reg;

  assign count_inc = count_reg + CNT_W'(1);

  // The counter measures how long the input has disagreed with the filtered
  // value. Any agreement restarts the measurement, so short glitches never
  // reach the threshold. The threshold compare happens on the incremented
  // value so the counter never has to hold a value beyond DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge sync_rst) begin
    if (!sync_rst) begin
      count_reg <= '0;
      filt_reg  <= 1'b0;
    end else if (in == filt_reg) begin
      count_reg <= '0;
    end else if (count_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
      filt_reg  <= in;
      count_reg <= '0;
    end else begin
      count_reg <= count_inc;
    end
  end

  assign out = filt_reg;
`else
  // Filter disabled: the synchronised value is used as-is.
  logic unused_cfg;
  assign unused_cfg = clk ^ sync_rst ^ (DEBOUNCE_CYCLES > 0);
  assign out = in;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller on the 16-bit IO bus.
// Drives N_OUT output pins from a writable register, synchronises (and, with
// the GPIO_DEBOUNCE_EN macro defined, debounces) N_IN input pins, latches
// rising edges into a sticky write-1-to-clear register, and raises a maskable
// registered interrupt while any enabled event is pending.
// Register map (word addresses, LSB aligned, unused bits read 0):
//   0 OUT rw, 1 IN ro, 2 EVT rw1c, 3 IEN rw; other addresses read 0.
// Ports:
//   clk       in  system clock, rising edge
//   sync_rst  in  asynchronous active-low reset
//   addr      in  register address
//   data      in  write data
//   write     in  write strobe
//   read      in  read strobe
//   data_out  out registered read data (1-cycle latency, holds when idle)
//   gpio_out  out output pins
//   gpio_in   in  asynchronous input pins
//   irq       out registered level interrupt
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int N_OUT           = 8,
  parameter int N_IN            = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic [N_OUT-1:0]  gpio_out,
  input  logic [N_IN-1:0]   gpio_in,
  output logic              irq
);

  logic [N_OUT-1:0]  out_reg;
  logic [N_IN-1:0]   evt_reg;
  logic [N_IN-1:0]   ien_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              irq_reg;
  logic [N_IN-1:0]   s1_reg;
  logic [N_IN-1:0]   s2_reg;
  logic [N_IN-1:0]   fp_reg;
  logic [N_IN-1:0]   filt;

  logic              sel_out;
  logic              sel_in;
  logic              sel_evt;
  logic              sel_ien;
  logic [DATA_W-1:0] read_value;
  logic [N_IN-1:0]   evt_clear;
  logic [N_IN-1:0]   rise;
  logic [N_IN-1:0]   evt_next;

  // Only the low bits of a write reach a register; the upper data bits are
  // deliberately ignored.
  logic unused_data;
  assign unused_data = ^data;

  // Full-width address compare: addresses above 3 never alias a register.
  assign sel_out = (addr == ADDR_W'(GPIO_REG_OUT));
  assign sel_in  = (addr == ADDR_W'(GPIO_REG_IN));
  assign sel_evt = (addr == ADDR_W'(GPIO_REG_EVT));
  assign sel_ien = (addr == ADDR_W'(GPIO_REG_IEN));

  // One filter per input bit, fed from the second synchroniser stage.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_filter
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .sync_rst(sync_rst),
      .in      (s2_reg[gi]),
      .out     (filt[gi])
    );
  end

  // Read mux works on current register contents, so a read in the same cycle
  // as a write returns the pre-write value.
  always_comb begin
    read_value = '0;
    if (sel_out) begin
      read_value[N_OUT-1:0] = out_reg;
    end else if (sel_in) begin
      read_value[N_IN-1:0] = filt;
    end else if (sel_evt) begin
      read_value[N_IN-1:0] = evt_reg;
    end else if (sel_ien) begin
      read_value[N_IN-1:0] = ien_reg;
    end
  end

  // A new rising edge is ORed in after the clear, so set wins over clear.
  assign rise      = filt & ~fp_reg;
  assign evt_clear = (write && sel_evt) ? data[N_IN-1:0] : '0;
  assign evt_next  = (evt_reg & ~evt_clear) | rise;

  always_ff @(posedge clk or negedge sync_rst) begin
    if (!sync_rst) begin
      out_reg      <= '0;
      evt_reg      <= '0;
      ien_reg      <= '0;
      data_out_reg <= '0;
      irq_reg      <= 1'b0;
      s1_reg       <= '0;
      s2_reg       <= '0;
      fp_reg       <= '0;
    end else begin
      s1_reg  <= gpio_in;
      s2_reg  <= s1_reg;
      fp_reg  <= filt;
      evt_reg <= evt_next;
      // Interrupt is computed from registered state only, one cycle behind EVT.
      irq_reg <= |(evt_reg & ien_reg);
      if (write && sel_out) begin
        out_reg <= data[N_OUT-1:0];
      end
      if (write && sel_ien) begin
        ien_reg <= data[N_IN-1:0];
      end
      if (read) begin
        data_out_reg <= read_value;
      end
    end
  end

  assign data_out = data_out_reg;
  assign gpio_out = out_reg;
  assign irq      = irq_reg;

endmodule
